dht11_reader: RTL
=================

# dht11_reader

Single-wire protocol engine for the DHT11 humidity/temperature sensor.
- Periodically issues the start pulse on the bidirectional data line, times the sensor response, and shifts in the 40-bit frame.
- Verifies the checksum and publishes the integer humidity and temperature bytes.
- Sits directly upstream of the binary-to-BCD conversion and the 4-digit FND display path in the sensor top level.
- Also drives an 8-bit status LED bar.

## Interface
Parameters:
- CLK_FREQ_HZ, 125_000_000: system clock frequency; must be a multiple of 1_000_000.
- READ_INTERVAL_US, 3_000_000: idle time between frames, and the delay from reset to the first frame.
- START_LOW_US, 18_000: host start-pulse low time.
- TIMEOUT_US, 200: maximum wait in any edge-wait state.
- BIT_THRESH_US, 50: a data-bit high time strictly greater than this value is decoded as 1.

Ports:
- clk, input, 1: system clock. One clock domain; reset is synchronous and active-high.
- reset_p, input, 1: synchronous active-high reset.
- dht11_data, inout, 1: open-drain line. Driven 0 when the host pulls low, otherwise high-Z (external pull-up).
- humidity, output, 8: integer RH byte of the last good frame.
- temperature, output, 8: integer temperature byte of the last good frame.
- data_valid, output, 1: one-cycle pulse when humidity/temperature update.
- chk_err, output, 1: set on checksum mismatch; cleared on the next good frame.
- timeout_err, output, 1: set on any wait timeout; cleared on the next good frame.
- LED_bar, output, 8: one-hot of the current state index; bit 7 = chk_err | timeout_err.

## Operation
Line input handling:
- 2-FF synchronizer on the line input.
- Rising and falling edges are detected on the synchronized value.

Time base:
- usec_tick pulses every CLK_FREQ_HZ/1_000_000 cycles.
- A 22-bit µs counter clears on every state entry and increments on usec_tick.

States:
- IDLE: line released. When count reaches READ_INTERVAL_US, go to START_LOW.
- START_LOW: drive 0. When count reaches START_LOW_US, release the line and go to WAIT_ACK.
- WAIT_ACK: falling edge goes to RESP_LOW.
- RESP_LOW: rising edge goes to RESP_HIGH.
- RESP_HIGH: falling edge clears the bit counter and goes to BIT_LOW.
- BIT_LOW: rising edge goes to BIT_HIGH.
- BIT_HIGH: on the falling edge:
  - shift in bit = (count > BIT_THRESH_US), MSB first, into a 40-bit register;
  - increment the bit counter;
  - if the bit counter is now 40, go to CHECK, else go to BIT_LOW.
- CHECK (one cycle): compare (b4+b3+b2+b1) mod 256 with b0, where b4 is the first byte received.
  - Match: humidity←b4, temperature←b2, pulse data_valid, clear both error flags.
  - Mismatch: set chk_err; humidity/temperature unchanged.
  - Both cases go to IDLE.

Timeouts:
- In any wait state (WAIT_ACK … BIT_HIGH), count reaching TIMEOUT_US sets timeout_err, releases the line, and goes to IDLE.
- The frame is discarded.

Other rules:
- The host never drives 1. The line is driven only in START_LOW.
- Edges seen in IDLE and START_LOW are ignored.

## Timing
Reset values:
- State IDLE, line released, all counters 0.
- humidity = 0, temperature = 0.
- data_valid = 0, chk_err = 0, timeout_err = 0.
- LED_bar = 8'b0000_0001.

Latencies:
- Line input to edge visible: 2 cycles (synchronizer) plus 1 cycle (edge register).
- The high-time measurement therefore has a ±1 µs granularity. Decoding is exact when the high time differs from the threshold by ≥2 µs.
- CHECK to outputs: outputs update on the CLK edge leaving CHECK; data_valid is high for exactly that one cycle.

Reset mid-frame:
- The line is released at the next clock edge.
- The partial frame is dropped.
- The interval restarts from 0.

Frame cadence:
- A new frame begins READ_INTERVAL_US + 1 µs after entry to IDLE, regardless of the previous frame's outcome.

## Structure
- Shared package dht11_pkg holds:
  - state encoding constants (IDLE=0 … CHECK=7);
  - FRAME_BITS = 40;
  - the default µs constants.
- Sub-module usec_tick_gen (parameter CLK_FREQ_HZ; ports clk, reset_p, tick) generates the µs strobe. It is reusable by other timing blocks.
- Remaining logic lives in one FSM module. The open-drain drive is a continuous assign of 1'b0 or 1'bz.

## Test plan
Bench setup: CLK_FREQ_HZ = 1_000_000 (one tick per cycle), READ_INTERVAL_US = 100, and a behavioural sensor model. The sensor model:
- answers 30 µs after release with 80 µs low and 80 µs high;
- encodes each bit as 50 µs low followed by 28 µs high for 0 or 70 µs high for 1.

Scenarios:
1. Good frame 0x37,0x00,0x19,0x00,0x50 → humidity=55, temperature=25, a single data_valid pulse, both errors 0.
2. Bad checksum 0x37,0x00,0x19,0x00,0x51 → chk_err=1, no data_valid, outputs keep their previous values (55/25 after scenario 1).
3. Silent sensor → line driven low for exactly 18_000 cycles, then timeout_err=1 200 µs after release; next start pulse follows after the interval.
4. Bit-width boundary: high times of 48 µs and 53 µs decode to 0 and 1 respectively. Frame 0x00,0x00,0x00,0x01,0x01 decodes as valid.
5. Assert reset_p during bit 20 → next cycle: line high-Z, LED_bar = 8'h01, outputs 0, no data_valid; a normal frame follows after the interval.
6. Back-to-back good frames 0x28,…,0x1E,…,0x46 → second data_valid arrives READ_INTERVAL_US + frame time after the first; humidity=40, temperature=30.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire reader: state encoding, frame size, default timings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_LOW = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_RESP_LOW  = 3'd3,
        ST_RESP_HIGH = 3'd4,
        ST_BIT_LOW   = 3'd5,
        ST_BIT_HIGH  = 3'd6,
        ST_CHECK     = 3'd7
    } state_t;

    localparam int FRAME_BITS = 40;
    localparam int US_CNT_W   = 22;

    localparam int DEF_CLK_FREQ_HZ      = 125_000_000;
    localparam int DEF_READ_INTERVAL_US = 3_000_000;
    localparam int DEF_START_LOW_US     = 18_000;
    localparam int DEF_TIMEOUT_US       = 200;
    localparam int DEF_BIT_THRESH_US    = 50;

    // Byte b0 of a good frame equals the mod-256 sum of b4..b1.
    function automatic logic [7:0] frame_sum(input logic [FRAME_BITS-1:0] f);
        frame_sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

endpackage

// File: rtl/usec_tick_gen.sv
// Microsecond strobe: one-cycle tick every CLK_FREQ_HZ/1e6 clocks.
// Latency: first tick one divider period after reset release.
// Backpressure: none, free-running.
module usec_tick_gen #(
    parameter int CLK_FREQ_HZ = 125_000_000
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + CW'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 protocol engine: periodic start pulse, response timing, 40-bit capture, checksum, publish.
// Latency: line edge seen 3 cycles after the pin moves; outputs update on the edge leaving CHECK.
// Backpressure: none; the sensor sets the pace and any stalled wait times out back to IDLE.
module dht11_reader
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = DEF_CLK_FREQ_HZ,
    parameter int READ_INTERVAL_US = DEF_READ_INTERVAL_US,
    parameter int START_LOW_US     = DEF_START_LOW_US,
    parameter int TIMEOUT_US       = DEF_TIMEOUT_US,
    parameter int BIT_THRESH_US    = DEF_BIT_THRESH_US
) (
    input  logic       clk,
    input  logic       reset_p,
    inout  wire        dht11_data,
    output logic [7:0] humidity,
    output logic [7:0] temperature,
    output logic       data_valid,
    output logic       chk_err,
    output logic       timeout_err,
    output logic [7:0] LED_bar
);

    localparam logic [US_CNT_W-1:0] INTERVAL_CNT = US_CNT_W'(READ_INTERVAL_US);
    localparam logic [US_CNT_W-1:0] START_CNT    = US_CNT_W'(START_LOW_US);
    localparam logic [US_CNT_W-1:0] TIMEOUT_CNT  = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0] THRESH_CNT   = US_CNT_W'(BIT_THRESH_US);
    localparam logic [5:0]          LAST_BIT     = 6'(FRAME_BITS - 1);

    logic                  tick;
    logic [2:0]            line_sync;
    logic                  line_rise;
    logic                  line_fall;
    state_t                state;
    state_t                state_nxt;
    logic [US_CNT_W-1:0]   us_cnt;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic                  shift_bit;
    logic                  clr_bits;
    logic                  timed_out;
    logic                  in_wait;
    logic                  drive_low;

    usec_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick)
    );

    // Released as soon as the count hits the target so the low time is exactly START_LOW_US.
    assign drive_low  = (state == ST_START_LOW) && (us_cnt < START_CNT);
    assign dht11_data = drive_low ? 1'b0 : 1'bz;

    assign line_rise = line_sync[1] & ~line_sync[2];
    assign line_fall = ~line_sync[1] & line_sync[2];
    assign in_wait   = state inside {ST_WAIT_ACK, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH};

    always_comb begin
        state_nxt = state;
        shift_bit = 1'b0;
        clr_bits  = 1'b0;
        timed_out = 1'b0;
        case (state)
            ST_IDLE:      if (us_cnt == INTERVAL_CNT) state_nxt = ST_START_LOW;
            ST_START_LOW: if (us_cnt == START_CNT) state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (line_fall) state_nxt = ST_RESP_LOW;
            ST_RESP_LOW:  if (line_rise) state_nxt = ST_RESP_HIGH;
            ST_RESP_HIGH: if (line_fall) begin
                clr_bits  = 1'b1;
                state_nxt = ST_BIT_LOW;
            end
            ST_BIT_LOW:   if (line_rise) state_nxt = ST_BIT_HIGH;
            ST_BIT_HIGH:  if (line_fall) begin
                shift_bit = 1'b1;
                state_nxt = (bit_cnt == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
            end
            ST_CHECK:     state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (in_wait && (state_nxt == state) && (us_cnt == TIMEOUT_CNT)) begin
            timed_out = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            line_sync   <= 3'b111;
            state       <= ST_IDLE;
            us_cnt      <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            humidity    <= '0;
            temperature <= '0;
            data_valid  <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            line_sync  <= {line_sync[1:0], dht11_data};
            state      <= state_nxt;
            data_valid <= 1'b0;
            if (state_nxt != state) begin
                us_cnt <= '0;
            end else if (tick) begin
                us_cnt <= us_cnt + US_CNT_W'(1);
            end
            if (clr_bits) begin
                bit_cnt <= '0;
            end
            // us_cnt here is the high time of the bit just ended.
            if (shift_bit) begin
                frame   <= {frame[FRAME_BITS-2:0], us_cnt > THRESH_CNT};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
            if (state == ST_CHECK) begin
                if (frame_sum(frame) == frame[7:0]) begin
                    humidity    <= frame[39:32];
                    temperature <= frame[23:16];
                    data_valid  <= 1'b1;
                    chk_err     <= 1'b0;
                    timeout_err <= 1'b0;
                end else begin
                    chk_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        LED_bar = '0;
        if (state != ST_CHECK) begin
            LED_bar[state] = 1'b1;
        end
        LED_bar[7] = chk_err | timeout_err;
    end

endmodule
